// File: rtl/pc_next_unit_pkg.sv
// Shared constants for the fetch-PC unit: branch_type bit positions,
// redirect mask, FSM state encoding and the default boot address.
package pc_next_unit_pkg;

  localparam int unsigned BT_PC4   = 0;
  localparam int unsigned BT_BTYPE = 1;
  localparam int unsigned BT_JAL   = 2;
  localparam int unsigned BT_JALR  = 3;
  localparam int unsigned BT_AUIPC = 4;

  // Branch types that change control flow (jalr, jal, btype).
  localparam logic [4:0] BT_REDIR_MASK = 5'b01110;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_REQ  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

endpackage

// File: rtl/pc_next_unit_target.sv
// Combinational redirect decode: target adder, jalr bit-0 mask and
// misalignment flag. PC_NEXT_RVC_EN relaxes the check to halfword alignment.
module pc_target_calc
  import pc_next_unit_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            ex_valid,
  input  logic [4:0]      branch_type,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_imm,
  input  logic [XLEN-1:0] ex_rs1,
  output logic            redir,
  output logic [XLEN-1:0] target,
  output logic            misalign
);

  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] rel_sum;

  assign jalr_sum = ex_rs1 + ex_imm;
  assign rel_sum  = ex_pc + ex_imm;

  always_comb begin
    redir  = ex_valid & (|(branch_type & BT_REDIR_MASK));
    target = '0;
    // Non-one-hot inputs resolve jalr over jal over btype.
    if (branch_type[BT_JALR]) begin
      target = jalr_sum & ~{{(XLEN-1){1'b0}}, 1'b1};
    end else if (branch_type[BT_JAL] || branch_type[BT_BTYPE]) begin
      target = rel_sum;
    end
  end

`ifdef PC_NEXT_RVC_EN
  assign misalign = target[0];
`else
  assign misalign = target[1];
`endif

endmodule

// File: rtl/pc_next_unit.sv
// Fetch PC owner: BOOT/REQ/HALT FSM, valid/ready fetch request, buffered
// redirect while stalled, flush pulse and misaligned-target halt.
// Optional macro: PC_NEXT_RVC_EN (halfword-aligned targets allowed).
module pc_next_unit
  import pc_next_unit_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_valid,
  input  logic [4:0]      branch_type,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_imm,
  input  logic [XLEN-1:0] ex_rs1,
  input  logic            fetch_ready,
  input  logic            exc_ack,
  input  logic [XLEN-1:0] exc_vec,
  output logic            fetch_valid,
  output logic [XLEN-1:0] fetch_pc,
  output logic            flush,
  output logic            misalign_exc,
  output logic [XLEN-1:0] exc_pc
);

  state_e          state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] pend_pc_q, pend_pc_d;
  logic            pend_q, pend_d;
  logic            flush_q, flush_d;
  logic            misalign_q, misalign_d;
  logic [XLEN-1:0] exc_pc_q, exc_pc_d;

  logic            redir;
  logic [XLEN-1:0] target;
  logic            misalign;

  pc_target_calc #(.XLEN(XLEN)) u_target (
    .ex_valid    (ex_valid),
    .branch_type (branch_type),
    .ex_pc       (ex_pc),
    .ex_imm      (ex_imm),
    .ex_rs1      (ex_rs1),
    .redir       (redir),
    .target      (target),
    .misalign    (misalign)
  );

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    pend_pc_d  = pend_pc_q;
    pend_d     = pend_q;
    flush_d    = 1'b0;
    misalign_d = misalign_q;
    exc_pc_d   = exc_pc_q;
    unique case (state_q)
      ST_BOOT: state_d = ST_REQ;
      ST_REQ: begin
        if (redir && misalign) begin
          state_d    = ST_HALT;
          flush_d    = 1'b1;
          misalign_d = 1'b1;
          exc_pc_d   = target;
          pend_d     = 1'b0;
        end else if (redir) begin
          flush_d = 1'b1;
          // A stalled request keeps its address; the target waits in pend_pc.
          if (fetch_ready) begin
            fetch_pc_d = target;
            pend_d     = 1'b0;
          end else begin
            pend_pc_d = target;
            pend_d    = 1'b1;
          end
        end else if (fetch_ready) begin
          if (pend_q) begin
            fetch_pc_d = pend_pc_q;
            pend_d     = 1'b0;
          end else begin
            fetch_pc_d = fetch_pc_q + XLEN'(4);
          end
        end
      end
      ST_HALT: begin
        if (exc_ack) begin
          state_d    = ST_REQ;
          fetch_pc_d = exc_vec;
          misalign_d = 1'b0;
        end
      end
      default: state_d = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_BOOT;
      fetch_pc_q <= RESET_PC;
      pend_pc_q  <= '0;
      pend_q     <= 1'b0;
      flush_q    <= 1'b0;
      misalign_q <= 1'b0;
      exc_pc_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      pend_pc_q  <= pend_pc_d;
      pend_q     <= pend_d;
      flush_q    <= flush_d;
      misalign_q <= misalign_d;
      exc_pc_q   <= exc_pc_d;
    end
  end

  assign fetch_valid  = (state_q == ST_REQ);
  assign fetch_pc     = fetch_pc_q;
  assign flush        = flush_q;
  assign misalign_exc = misalign_q;
  assign exc_pc       = exc_pc_q;

endmodule

// File: doc/pc_next_unit.md
Name: pc_next_unit

Overview:
- Downstream consumer of the execute-stage branch decision (one-hot branch_type {auipc, jalr, jal, btype, pc4}).
- Computes branch/jump targets and owns the architectural fetch PC register.
- Drives fetch requests over a valid/ready handshake and buffers a redirect that arrives while a request is stalled.
- Signals the pipeline flush and raises a misaligned-target exception.

Parameters:
- RESET_PC, 32'h8000_0000, first fetch address after reset.
- XLEN, 32, address/data width.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  synchronous active-low reset.
- ex_valid  in  1  execute-stage instruction valid this cycle.
- branch_type  in  5  one-hot {auipc, jalr, jal, btype, pc4} from the branch decision.
- ex_pc  in  XLEN  PC of the execute-stage instruction.
- ex_imm  in  XLEN  sign-extended immediate.
- ex_rs1  in  XLEN  rs1 operand (jalr base).
- fetch_ready  in  1  fetch side accepts the request.
- exc_ack  in  1  trap handler acknowledges the exception; resume.
- exc_vec  in  XLEN  resume address applied with exc_ack.
- fetch_valid  out  1  request valid.
- fetch_pc  out  XLEN  request address.
- flush  out  1  one-cycle pulse: kill younger in-flight instructions.
- misalign_exc  out  1  held high in HALT.
- exc_pc  out  XLEN  offending target address.

Behaviour:
- Reset (rst_n=0 at edge):
  - state=BOOT; fetch_pc=RESET_PC; fetch_valid=0; flush=0; misalign_exc=0; exc_pc=0.
  - Pending-redirect flag cleared.
- States:
  - BOOT -> REQ unconditionally, after one cycle.
  - REQ: fetch_valid=1. On fetch_valid&fetch_ready, fetch_pc <= next (see precedence). REQ -> HALT on a misaligned redirect.
  - HALT: fetch_valid=0. HALT -> REQ on exc_ack, with fetch_pc<=exc_vec and misalign_exc cleared.
- Redirect decode (ex_valid=1 only):
  - jalr: target = (ex_rs1+ex_imm) & ~1.
  - jal or btype: target = ex_pc+ex_imm.
  - pc4 or auipc: no redirect.
  - Non-one-hot input: priority jalr > jal > btype.
  - All adds are modulo 2^XLEN; wrap-around is silent.
- Misalignment: target[1]!=0 (after the jalr bit0 clear).
  - Next cycle: misalign_exc=1, exc_pc=target, state=HALT, flush=1 for one cycle.
  - Any pending redirect is discarded.
- Aligned redirect in REQ:
  - flush=1 the following cycle.
  - If not (fetch_valid & !fetch_ready): fetch_pc<=target next cycle.
  - Else: latch pending_pc=target and set the pending flag. fetch_pc stays stable until the handshake completes, then fetch_pc<=pending_pc and the flag is cleared.
- Precedence for fetch_pc update, highest first:
  1. reset
  2. exc_ack in HALT
  3. new redirect this cycle (overwrites pending)
  4. pending redirect on handshake
  5. fetch_pc+4 on handshake
  6. hold
- Redirect coinciding with a handshake: the handshake completes and fetch_pc<=target (no +4).
- Handshake rule: while fetch_valid & !fetch_ready, fetch_pc must not change.
- Redirect in BOOT or HALT: ignored; no flush.
- Reset mid-request or mid-HALT: returns to BOOT with all outputs at reset values.

Optional Feature:
- Macro PC_NEXT_RVC_EN.
- Defined:
  - Misalignment checks target[0] only, which is always 0 after decode, so no misaligned exception is ever raised.
  - Sequential increment remains +4, because the fetch unit handles halfword packing.
- Undefined: target[1] check as above.

Decomposition:
- Shared package:
  - Branch_type bit-index constants BT_PC4=0, BT_BTYPE=1, BT_JAL=2, BT_JALR=3, BT_AUIPC=4.
  - State encoding constants ST_BOOT, ST_REQ, ST_HALT.
  - RESET_PC default.
- One natural sub-module: pc_target_calc (combinational target adder, jalr mask, misalign flag). FSM and registers stay in pc_next_unit.

Test Plan:
1. Reset release, fetch_ready=1 constantly -> fetch_pc sequence 0x80000000, 0x80000004, 0x80000008; flush=0.
2. jal: ex_pc=0x80000010, imm=0x20 -> flush pulse 1 cycle, next fetch_pc=0x80000030.
3. jalr: rs1=0x80001003, imm=0 -> target 0x80001002 -> misalign_exc=1, exc_pc=0x80001002, fetch_valid=0. Then exc_ack with exc_vec=0x80000100 -> fetch_pc=0x80000100.
4. fetch_ready=0 holding fetch_pc=0x80000008, btype redirect to 0x80000040 -> fetch_pc stays 0x80000008 until ready. After the handshake fetch_pc=0x80000040, not 0x8000000C.
5. branch_type=pc4 or auipc with ex_valid=1 -> no flush, sequential +4. Repeat with ex_valid=0 and jal bit set -> ignored.
6. fetch_pc=0xFFFFFFFC handshake -> wraps to 0x00000000. Also: reset asserted during pending redirect -> fetch_pc=RESET_PC, pending flag cleared.
